id_ex_stage: RTL and testbench

- ID/EX pipeline register directly downstream of the opcode control decoder.
- Each cycle it captures the decoder's 10-bit control bundle together with the ID-stage operands and register specifiers. It presents them to the EX stage one cycle later.
- Contains load-use hazard detection. On a hazard it inserts a bubble and asserts a stall back to the PC and IF/ID register.
- Honours an external stall and a branch-taken flush.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/load_use_detect.sv | 21 ++
 rtl/id_ex_stage.sv | 114 +++++++++++
 tb/tb_id_ex_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: control bundle bit positions, the bubble
// encoding, and the opcode constants also used by the control decoder.
package mips_pkg;

    localparam int CTRL_W        = 10;
    localparam int CTRL_ALUSRC   = 9;
    localparam int CTRL_ALUOP_HI = 8;
    localparam int CTRL_ALUOP_LO = 6;
    localparam int CTRL_REGDST   = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_REGWRITE = 0;

    // NOP bundle: nothing writes memory, registers, or redirects the PC.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 10'b0000000010;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: a valid load in EX whose destination (rt)
// matches either source specifier of a valid ID instruction.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              exValid,
    input  logic              exMemRead,
    input  logic [REG_AW-1:0] exRt,
    input  logic              idValid,
    input  logic [REG_AW-1:0] idRs,
    input  logic [REG_AW-1:0] idRt,
    output logic              hz
);

    // rt is compared even for I-type consumers; a spurious stall is harmless.
    always_comb begin
        hz = exValid & exMemRead & (exRt != '0) & idValid &
             ((exRt == idRs) | (exRt == idRt));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, external stall and
// branch flush. Optional bubble counter enabled by IDEX_BUBBLE_CNT_EN.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [DATA_W-1:0] pc4_in,
    input  logic [REG_AW-1:0] rs_in,
    input  logic [REG_AW-1:0] rt_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              stall_in,
    input  logic              flush_in,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [DATA_W-1:0] pc4_out,
    output logic [REG_AW-1:0] rs_out,
    output logic [REG_AW-1:0] rt_out,
    output logic [REG_AW-1:0] rd_out,
    output logic              hazard_stall
`ifdef IDEX_BUBBLE_CNT_EN
    ,output logic [15:0]      bubble_cnt
`endif
);

    logic hz;

    load_use_detect #(.REG_AW(REG_AW)) uDetect (
        .exValid   (valid_out),
        .exMemRead (ctrl_out[CTRL_MEMREAD]),
        .exRt      (rt_out),
        .idValid   (valid_in),
        .idRs      (rs_in),
        .idRt      (rt_in),
        .hz        (hz)
    );

    // A flushed or frozen ID slot must not also freeze PC/IF-ID.
    always_comb begin
        hazard_stall = hz & ~flush_in & ~stall_in;
    end

    // Pipeline register: flush > stall > hazard bubble > load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_out  <= CTRL_BUBBLE;
            valid_out <= 1'b0;
            rd1_out   <= '0;
            rd2_out   <= '0;
            imm_out   <= '0;
            pc4_out   <= '0;
            rs_out    <= '0;
            rt_out    <= '0;
            rd_out    <= '0;
        end else if (flush_in) begin
            // Data contents are don't-care behind a bubble; loading keeps muxing simple.
            ctrl_out  <= CTRL_BUBBLE;
            valid_out <= 1'b0;
            rd1_out   <= rd1_in;
            rd2_out   <= rd2_in;
            imm_out   <= imm_in;
            pc4_out   <= pc4_in;
            rs_out    <= rs_in;
            rt_out    <= rt_in;
            rd_out    <= rd_in;
        end else if (stall_in) begin
            ctrl_out  <= ctrl_out;
            valid_out <= valid_out;
        end else if (hz) begin
            // Specifiers are left untouched so the held ID instruction reloads cleanly.
            ctrl_out  <= CTRL_BUBBLE;
            valid_out <= 1'b0;
        end else begin
            ctrl_out  <= valid_in ? ctrl_in : CTRL_BUBBLE;
            valid_out <= valid_in;
            rd1_out   <= rd1_in;
            rd2_out   <= rd2_in;
            imm_out   <= imm_in;
            pc4_out   <= pc4_in;
            rs_out    <= rs_in;
            rt_out    <= rt_in;
            rd_out    <= rd_in;
        end
    end

`ifdef IDEX_BUBBLE_CNT_EN
    logic bubbleIns;

    // A bubble enters EX on a flush, or on a hazard not masked by a stall.
    always_comb begin
        bubbleIns = flush_in | (hz & ~stall_in);
    end

    // Saturating bubble counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bubble_cnt <= '0;
        else if (bubbleIns && bubble_cnt != 16'hFFFF)
            bubble_cnt <= bubble_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam logic [9:0] C_R  = 10'b0010100011;
    localparam logic [9:0] C_LW = 10'b1000001001;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ctrl_in;
    logic        valid_in;
    logic [31:0] rd1_in, rd2_in, imm_in, pc4_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic        stall_in, flush_in;
    logic [9:0]  ctrl_out;
    logic        valid_out;
    logic [31:0] rd1_out, rd2_out, imm_out, pc4_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic        hazard_stall;
`ifdef IDEX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in), .pc4_in(pc4_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .stall_in(stall_in), .flush_in(flush_in),
        .ctrl_out(ctrl_out), .valid_out(valid_out),
        .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out), .pc4_out(pc4_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .hazard_stall(hazard_stall)
`ifdef IDEX_BUBBLE_CNT_EN
        ,.bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] c, input logic v, input logic [31:0] r1,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        ctrl_in  = c;
        valid_in = v;
        rd1_in   = r1;
        rd2_in   = r1 + 32'h1000;
        imm_in   = r1 + 32'h2000;
        pc4_in   = r1 + 32'h3000;
        rs_in    = s;
        rt_in    = t;
        rd_in    = d;
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        drive(10'h3FF, 1'b1, 32'hDEAD, 5'd7, 5'd8, 5'd9);
        repeat (2) tick();
        chk("rst_ctrl", 32'(ctrl_out), 32'(CTRL_BUBBLE));
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_rd1", rd1_out, 32'd0);
        chk("rst_rt", 32'(rt_out), 32'd0);
        chk("rst_hz", 32'(hazard_stall), 32'd0);
        rst = 1'b0;

        // Pass-through of an R-type instruction
        drive(C_R, 1'b1, 32'h11, 5'd1, 5'd2, 5'd3);
        rd2_in = 32'h22; imm_in = 32'h33; pc4_in = 32'h44;
        #1 chk("pt_hz", 32'(hazard_stall), 32'd0);
        tick();
        chk("pt_ctrl", 32'(ctrl_out), 32'(C_R));
        chk("pt_valid", 32'(valid_out), 32'd1);
        chk("pt_rd1", rd1_out, 32'h11);
        chk("pt_rd2", rd2_out, 32'h22);
        chk("pt_imm", imm_out, 32'h33);
        chk("pt_pc4", pc4_out, 32'h44);
        chk("pt_spec", {17'd0, rs_out, rt_out, rd_out}, {17'd0, 5'd1, 5'd2, 5'd3});

        // Load-use: LW rt=5 followed by ADD rs=5
        drive(C_LW, 1'b1, 32'h100, 5'd1, 5'd5, 5'd0);
        #1 chk("lw_nohz", 32'(hazard_stall), 32'd0);
        tick();
        chk("lw_ctrl", 32'(ctrl_out), 32'(C_LW));
        drive(C_R, 1'b1, 32'h55, 5'd5, 5'd6, 5'd7);
        #1 chk("lu_hz", 32'(hazard_stall), 32'd1);
        tick();
        chk("lu_bub_ctrl", 32'(ctrl_out), 32'(CTRL_BUBBLE));
        chk("lu_bub_valid", 32'(valid_out), 32'd0);
        chk("lu_bub_rt", 32'(rt_out), 32'd5);
        chk("lu_bub_rd1", rd1_out, 32'h100);
        chk("lu_hz_drop", 32'(hazard_stall), 32'd0);
        tick();
        chk("lu_add_ctrl", 32'(ctrl_out), 32'(C_R));
        chk("lu_add_rs", 32'(rs_out), 32'd5);
        chk("lu_add_rd1", rd1_out, 32'h55);
        chk("lu_add_valid", 32'(valid_out), 32'd1);

        // rt_out == 0 never hazards
        drive(C_LW, 1'b1, 32'h200, 5'd1, 5'd0, 5'd0);
        tick();
        drive(C_R, 1'b1, 32'h66, 5'd0, 5'd0, 5'd4);
        #1 chk("rt0_hz", 32'(hazard_stall), 32'd0);
        tick();
        chk("rt0_ctrl", 32'(ctrl_out), 32'(C_R));
        chk("rt0_rd1", rd1_out, 32'h66);

        // Flush beats hazard
        drive(C_LW, 1'b1, 32'h300, 5'd1, 5'd5, 5'd0);
        tick();
        drive(C_R, 1'b1, 32'h77, 5'd5, 5'd6, 5'd7);
        flush_in = 1'b1;
        #1 chk("fl_hz", 32'(hazard_stall), 32'd0);
        tick();
        flush_in = 1'b0;
        chk("fl_ctrl", 32'(ctrl_out), 32'(CTRL_BUBBLE));
        chk("fl_valid", 32'(valid_out), 32'd0);

        // External stall for 3 cycles with a pending hazard
        drive(C_LW, 1'b1, 32'h400, 5'd2, 5'd9, 5'd0);
        tick();
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(C_R, 1'b1, 32'h500 + 32'(i), 5'd9, 5'd3, 5'd4);
            #1 chk("st_hz", 32'(hazard_stall), 32'd0);
            tick();
            chk("st_ctrl", 32'(ctrl_out), 32'(C_LW));
            chk("st_rd1", rd1_out, 32'h400);
            chk("st_rt", 32'(rt_out), 32'd9);
            chk("st_valid", 32'(valid_out), 32'd1);
        end
        stall_in = 1'b0;
        #1 chk("st_release_hz", 32'(hazard_stall), 32'd1);
        tick();
        chk("st_bub_ctrl", 32'(ctrl_out), 32'(CTRL_BUBBLE));
        tick();
        chk("st_add_rd1", rd1_out, 32'h502);
        chk("st_add_ctrl", 32'(ctrl_out), 32'(C_R));

        // Invalid ID slot loads a bubble regardless of ctrl_in
        drive(10'h3FF, 1'b0, 32'h600, 5'd1, 5'd2, 5'd3);
        tick();
        chk("inv_ctrl", 32'(ctrl_out), 32'(CTRL_BUBBLE));
        chk("inv_valid", 32'(valid_out), 32'd0);

`ifdef IDEX_BUBBLE_CNT_EN
        chk("bcnt", 32'(bubble_cnt), 32'd3);
`endif

        // Mid-cycle reset during a hazard
        drive(C_LW, 1'b1, 32'h700, 5'd1, 5'd5, 5'd0);
        tick();
        drive(C_R, 1'b1, 32'h88, 5'd5, 5'd6, 5'd7);
        #1 chk("mr_hz_pre", 32'(hazard_stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_ctrl", 32'(ctrl_out), 32'(CTRL_BUBBLE));
        chk("mr_valid", 32'(valid_out), 32'd0);
        chk("mr_rd1", rd1_out, 32'd0);
        chk("mr_hz", 32'(hazard_stall), 32'd0);
`ifdef IDEX_BUBBLE_CNT_EN
        chk("mr_bcnt", 32'(bubble_cnt), 32'd0);
`endif
        tick();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
